// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared segment patterns, digit indices and decimal-point mask for the stopwatch display
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package stopwatch_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] DIG_TENTHS = 2'd0;
    localparam logic [1:0] DIG_ONES   = 2'd1;
    localparam logic [1:0] DIG_TENS   = 2'd2;
    localparam logic [1:0] DIG_MIN    = 2'd3;

    // Bit set = decimal point lit after that digit (ones and minutes).
    localparam logic [3:0] DP_MASK = 4'b1010;

endpackage

// File: rtl/stopwatch_display_bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-low 7-segment decoder, dash for 10-15
// Ports: bcd (in, 4) digit value; seg (out, 7) active-low {g,f,e,d,c,b,a}.
module bcd_to_seg7
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/stopwatch_display.sv
// stopwatch_display: snapshots four BCD digits and scans them onto a 4-digit common-anode 7-segment display
// Parameters: REFRESH_DIV clk cycles per digit slot (>=2); BLANK_CYCLES anode-off cycles at slot start (<REFRESH_DIV).
// Ports: clk, reset (sync, active-high); update samples minutes/tens_seconds/ones_seconds/tenths_seconds;
//        an (active-low anodes, an[3]=minutes..an[0]=tenths), seg (active-low {g..a}), dp (active-low); all registered.
// Build option: LEADING_ZERO_BLANK_EN blanks a zero minutes digit, and the tens digit when minutes and tens are both zero.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       update,
    input  logic [3:0] minutes,
    input  logic [3:0] tens_seconds,
    input  logic [3:0] ones_seconds,
    input  logic [3:0] tenths_seconds,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    // Snapshot indexed by digit index: [0]=tenths .. [3]=minutes.
    logic [3:0][3:0] snap_q, snap_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [6:0]      dec_seg;
    logic            blank;

    bcd_to_seg7 u_dec (
        .bcd (snap_q[idx_q]),
        .seg (dec_seg)
    );

    always_comb begin
        snap_d = update ? {minutes, tens_seconds, ones_seconds, tenths_seconds} : snap_q;
        cnt_d  = (cnt_q == CW'(REFRESH_DIV - 1)) ? '0 : cnt_q + 1'b1;
        idx_d  = (cnt_q == CW'(REFRESH_DIV - 1)) ? idx_q + 2'd1 : idx_q;
`ifdef LEADING_ZERO_BLANK_EN
        blank  = (idx_q == DIG_MIN  && snap_q[DIG_MIN] == 4'd0) ||
                 (idx_q == DIG_TENS && snap_q[DIG_MIN] == 4'd0 && snap_q[DIG_TENS] == 4'd0);
`else
        blank  = 1'b0;
`endif
        // Only the anodes are gated during the blank window; seg/dp keep the digit.
        an_d   = (cnt_q < CW'(BLANK_CYCLES)) ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d  = blank ? SEG_BLANK : dec_seg;
        dp_d   = blank | ~DP_MASK[idx_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= DIG_TENTHS;
            snap_q <= '0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display: randomized self-checking bench against a time-indexed display model
module tb_stopwatch_display;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic       clk = 1'b0;
    logic       reset, update;
    logic [3:0] minutes, tens_seconds, ones_seconds, tenths_seconds;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;
    int t = 0;
    int snap [4];

    stopwatch_display #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk            (clk),
        .reset          (reset),
        .update         (update),
        .minutes        (minutes),
        .tens_seconds   (tens_seconds),
        .ones_seconds   (ones_seconds),
        .tenths_seconds (tenths_seconds),
        .an             (an),
        .seg            (seg),
        .dp             (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_digits(input int m, input int ts, input int os, input int th);
        minutes        = 4'(m);
        tens_seconds   = 4'(ts);
        ones_seconds   = 4'(os);
        tenths_seconds = 4'(th);
    endtask

    // t counts cycles since the scan restarted; slot and position follow from it directly.
    task automatic step(input string tag);
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        int i, c, d;
        if (reset) begin
            ea = 4'hF; es = 7'h7F; ed = 1'b1;
        end else begin
            i  = (t / DIV) % 4;
            c  = t % DIV;
            d  = snap[i];
            ea = (c < BLANK) ? 4'hF : ~(4'(1) << i);
            es = (d > 9) ? 7'b0111111 : PAT[d];
            ed = !(i == 1 || i == 3);
`ifdef LEADING_ZERO_BLANK_EN
            if ((i == 3 && snap[3] == 0) || (i == 2 && snap[3] == 0 && snap[2] == 0)) begin
                es = 7'h7F; ed = 1'b1;
            end
`endif
        end
        @(posedge clk);
        if (reset) begin
            t = 0;
            for (int k = 0; k < 4; k++) snap[k] = 0;
        end else begin
            if (update) begin
                snap[0] = int'(tenths_seconds);
                snap[1] = int'(ones_seconds);
                snap[2] = int'(tens_seconds);
                snap[3] = int'(minutes);
            end
            t = (t + 1) % (4 * DIV);
        end
        #1;
        check({tag, ".an"},  32'(an),  32'(ea));
        check({tag, ".seg"}, 32'(seg), 32'(es));
        check({tag, ".dp"},  32'(dp),  32'(ed));
    endtask

    task automatic load(input string tag, input int m, input int ts, input int os, input int th);
        set_digits(m, ts, os, th);
        update = 1'b1;
        step(tag);
        update = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) snap[k] = 0;
        reset  = 1'b1;
        update = 1'b0;
        set_digits(0, 0, 0, 0);
        repeat (3) step("reset");
        reset = 1'b0;
        repeat (8) step("release");
        load("load1508", 1, 5, 0, 8);
        repeat (32) step("scan1508");
        set_digits(9, 4, 6, 2);
        repeat (32) step("hold");
        load("upd9462", 9, 4, 6, 2);
        repeat (32) step("scan9462");
        load("dash", 9, 4, 6, 12);
        repeat (32) step("scandash");
        for (int k = 0; k < 64 && t != 2 * DIV + 5; k++) step("seek");
        reset = 1'b1;
        step("midreset");
        reset = 1'b0;
        repeat (16) step("restart");
        load("load0073", 0, 0, 7, 3);
        repeat (32) step("scan0073");
        load("load0573", 0, 5, 7, 3);
        repeat (32) step("scan0573");
        for (int k = 0; k < 64 && t % DIV != DIV - 1; k++) step("seekwrap");
        load("wrapload", 3, 2, 1, 15);
        repeat (32) step("scanwrap");
        update = 1'b1;
        repeat (64) begin
            set_digits($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            step("live");
        end
        update = 1'b0;
        repeat (1500) begin
            update = ($urandom_range(0, 7) == 0);
            reset  = ($urandom_range(0, 199) == 0);
            set_digits($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                minutes      = 4'd0;
                tens_seconds = 4'($urandom_range(0, 1));
            end
            step("rand");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
